html_tag_parser: RTL and testbench

HTML_TAG_PARSER -- requirements
Module: html_tag_parser

---
 rtl/html_tag_parser.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_html_tag_parser.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/html_tag_parser.sv
// html_tag_parser: streaming HTML-subset tokenizer. It accepts one ASCII char
// per enabled edge and emits registered one-cycle tag/attribute/text tokens.
// Tag and attribute names share one shift buffer, because a tag name and an
// attribute name are never being collected at the same time.

`ifndef CHAR_BITES
`define CHAR_BITES 8
`endif

module html_tag_parser #(
  parameter int NAME_LEN = 10
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_state_enable,
  input  logic [`CHAR_BITES-1:0] i_char,
  input  logic                   i_char_valid,
  output logic                   o_tag_valid,
  output logic [1:0]             o_tag_id,
  output logic                   o_tag_is_close,
  output logic                   o_attr_valid,
  output logic [1:0]             o_attr_id,
  output logic [3:0]             o_attr_value,
  output logic                   o_text_valid,
  output logic [`CHAR_BITES-1:0] o_text_char,
  output logic                   o_has_finished,
  output logic                   o_error
);

  // Name length counter must hold NAME_LEN+1 (overflow marker) and at least 10.
  localparam int LEN_W_MIN = $clog2(NAME_LEN + 2);
  localparam int LEN_W     = (LEN_W_MIN > 4) ? LEN_W_MIN : 4;
  localparam int BUF_W     = NAME_LEN * 8;
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(NAME_LEN + 1);

  localparam logic [7:0] C_NUL = 8'h00;
  localparam logic [7:0] C_LT  = 8'h3C;
  localparam logic [7:0] C_GT  = 8'h3E;
  localparam logic [7:0] C_SL  = 8'h2F;
  localparam logic [7:0] C_SP  = 8'h20;
  localparam logic [7:0] C_EQ  = 8'h3D;

  typedef enum logic [2:0] {
    ST_TEXT,
    ST_TAG_OPEN,
    ST_TAG_NAME,
    ST_ATTR_SEP,
    ST_ATTR_NAME,
    ST_ATTR_VALUE,
    ST_DONE,
    ST_ERR
  } state_t;

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= 8'h61) && (c <= 8'h7A)) || ((c >= 8'h41) && (c <= 8'h5A));
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // The buffer is a left-shifting register cleared on the first char, so a
  // name of exactly lit_len chars sits right-aligned like a hex string literal.
  function automatic logic name_is(input logic [79:0] nm, input logic [LEN_W-1:0] len,
                                   input logic [79:0] lit, input int lit_len);
    return (lit_len <= NAME_LEN) && (int'(len) == lit_len) && (nm == lit);
  endfunction

  function automatic logic [1:0] tag_lookup(input logic [79:0] nm, input logic [LEN_W-1:0] len);
    logic [1:0] id;
    if (name_is(nm, len, 80'h626F6479, 4)) begin            // "body"
      id = 2'd1;
    end else if (name_is(nm, len, 80'h70, 1)) begin         // "p"
      id = 2'd2;
    end else begin
      id = 2'd0;
    end
    return id;
  endfunction

  function automatic logic [1:0] attr_lookup(input logic [79:0] nm, input logic [LEN_W-1:0] len);
    logic [1:0] id;
    if (name_is(nm, len, 80'h6261636B67726F756E64, 10)) begin  // "background"
      id = 2'd1;
    end else if (name_is(nm, len, 80'h636F6C6F72, 5)) begin    // "color"
      id = 2'd2;
    end else if (name_is(nm, len, 80'h73697A65, 4)) begin      // "size"
      id = 2'd3;
    end else begin
      id = 2'd0;
    end
    return id;
  endfunction

  state_t           r_state, w_state_nxt;
  logic [BUF_W-1:0] r_name, w_name_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic             r_close, w_close_nxt;
  logic [3:0]       r_value, w_value_nxt;
  logic             r_have_digit, w_have_digit_nxt;
  logic             r_tag_valid, w_tag_valid_nxt;
  logic [1:0]       r_tag_id, w_tag_id_nxt;
  logic             r_tag_close, w_tag_close_nxt;
  logic             r_attr_valid, w_attr_valid_nxt;
  logic [1:0]       r_attr_id, w_attr_id_nxt;
  logic [3:0]       r_attr_value, w_attr_value_nxt;
  logic             r_text_valid, w_text_valid_nxt;
  logic [7:0]       r_text_char, w_text_char_nxt;
  logic             r_finished, w_finished_nxt;
  logic             r_error, w_error_nxt;

  logic [BUF_W+7:0] w_name_cat;
  logic [BUF_W-1:0] w_name_app;
  logic [BUF_W-1:0] w_name_first;
  logic [LEN_W-1:0] w_len_inc;
  logic [79:0]      w_name80;
  logic [7:0]       w_value_calc;
  logic [3:0]       w_value_sat;
  logic             w_in_tag;

  assign w_name_cat   = {r_name, i_char};
  // Chars past NAME_LEN are counted but not stored.
  assign w_name_app   = (int'(r_len) < NAME_LEN) ? w_name_cat[BUF_W-1:0] : r_name;
  assign w_name_first = BUF_W'(i_char);
  assign w_len_inc    = (r_len == LEN_SAT) ? r_len : (r_len + LEN_W'(1));
  assign w_name80     = 80'(r_name);
  assign w_value_calc = ({4'h0, r_value} * 8'd10) + {4'h0, i_char[3:0]};
  assign w_value_sat  = (w_value_calc > 8'd15) ? 4'hF : w_value_calc[3:0];

  // Next-state and next-output logic; token pulses default low every cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_name_nxt       = r_name;
    w_len_nxt        = r_len;
    w_close_nxt      = r_close;
    w_value_nxt      = r_value;
    w_have_digit_nxt = r_have_digit;
    w_tag_valid_nxt  = 1'b0;
    w_tag_id_nxt     = 2'd0;
    w_tag_close_nxt  = 1'b0;
    w_attr_valid_nxt = 1'b0;
    w_attr_id_nxt    = 2'd0;
    w_attr_value_nxt = 4'd0;
    w_text_valid_nxt = 1'b0;
    w_text_char_nxt  = 8'd0;
    w_finished_nxt   = r_finished;
    w_error_nxt      = r_error;
    w_in_tag         = (r_state == ST_TAG_OPEN) || (r_state == ST_TAG_NAME) ||
                       (r_state == ST_ATTR_SEP) || (r_state == ST_ATTR_NAME) ||
                       (r_state == ST_ATTR_VALUE);

    if (!i_char_valid) begin
      w_state_nxt = r_state;
    end else if (w_in_tag && ((i_char == C_LT) || (i_char == C_NUL))) begin
      // A tag interrupted by a new '<' or end-of-stream is malformed.
      w_state_nxt    = ST_ERR;
      w_error_nxt    = 1'b1;
      w_finished_nxt = r_finished | (i_char == C_NUL);
    end else begin
      case (r_state)
        ST_TEXT: begin
          if (i_char == C_LT) begin
            w_state_nxt = ST_TAG_OPEN;
            w_close_nxt = 1'b0;
          end else if (i_char == C_NUL) begin
            w_state_nxt    = ST_DONE;
            w_finished_nxt = 1'b1;
          end else begin
            w_text_valid_nxt = 1'b1;
            w_text_char_nxt  = i_char;
          end
        end
        ST_TAG_OPEN: begin
          if ((i_char == C_SL) && !r_close) begin
            w_close_nxt = 1'b1;
          end else if (is_letter(i_char)) begin
            w_state_nxt = ST_TAG_NAME;
            w_name_nxt  = w_name_first;
            w_len_nxt   = LEN_W'(1);
          end else begin
            w_state_nxt = ST_ERR;
            w_error_nxt = 1'b1;
          end
        end
        ST_TAG_NAME: begin
          if (is_letter(i_char)) begin
            w_name_nxt = w_name_app;
            w_len_nxt  = w_len_inc;
          end else if ((i_char == C_SP) || (i_char == C_GT)) begin
            w_tag_valid_nxt = 1'b1;
            w_tag_id_nxt    = tag_lookup(w_name80, r_len);
            w_tag_close_nxt = r_close;
            w_state_nxt     = (i_char == C_SP) ? ST_ATTR_SEP : ST_TEXT;
          end else begin
            w_state_nxt = ST_ERR;
            w_error_nxt = 1'b1;
          end
        end
        ST_ATTR_SEP: begin
          if (i_char == C_SP) begin
            w_state_nxt = ST_ATTR_SEP;
          end else if (i_char == C_GT) begin
            w_state_nxt = ST_TEXT;
          end else if (is_letter(i_char) && !r_close) begin
            w_state_nxt = ST_ATTR_NAME;
            w_name_nxt  = w_name_first;
            w_len_nxt   = LEN_W'(1);
          end else begin
            w_state_nxt = ST_ERR;
            w_error_nxt = 1'b1;
          end
        end
        ST_ATTR_NAME: begin
          if (is_letter(i_char)) begin
            w_name_nxt = w_name_app;
            w_len_nxt  = w_len_inc;
          end else if (i_char == C_EQ) begin
            w_state_nxt      = ST_ATTR_VALUE;
            w_value_nxt      = 4'd0;
            w_have_digit_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_ERR;
            w_error_nxt = 1'b1;
          end
        end
        ST_ATTR_VALUE: begin
          if (is_digit(i_char)) begin
            w_value_nxt      = w_value_sat;
            w_have_digit_nxt = 1'b1;
          end else if (((i_char == C_SP) || (i_char == C_GT)) && r_have_digit) begin
            w_attr_valid_nxt = 1'b1;
            w_attr_id_nxt    = attr_lookup(w_name80, r_len);
            w_attr_value_nxt = r_value;
            w_state_nxt      = (i_char == C_SP) ? ST_ATTR_SEP : ST_TEXT;
          end else begin
            w_state_nxt = ST_ERR;
            w_error_nxt = 1'b1;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_DONE;
        end
        ST_ERR: begin
          w_error_nxt = 1'b1;
          if (i_char == C_NUL) begin
            w_finished_nxt = 1'b1;
          end else begin
            w_finished_nxt = r_finished;
          end
        end
        default: begin
          w_state_nxt = ST_ERR;
          w_error_nxt = 1'b1;
        end
      endcase
    end
  end

  // State, buffers and output registers; reset or dropped enable clears all.
  always_ff @(posedge i_clock) begin
    if (i_reset || !i_state_enable) begin
      r_state      <= ST_TEXT;
      r_name       <= '0;
      r_len        <= '0;
      r_close      <= 1'b0;
      r_value      <= 4'd0;
      r_have_digit <= 1'b0;
      r_tag_valid  <= 1'b0;
      r_tag_id     <= 2'd0;
      r_tag_close  <= 1'b0;
      r_attr_valid <= 1'b0;
      r_attr_id    <= 2'd0;
      r_attr_value <= 4'd0;
      r_text_valid <= 1'b0;
      r_text_char  <= 8'd0;
      r_finished   <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_name       <= w_name_nxt;
      r_len        <= w_len_nxt;
      r_close      <= w_close_nxt;
      r_value      <= w_value_nxt;
      r_have_digit <= w_have_digit_nxt;
      r_tag_valid  <= w_tag_valid_nxt;
      r_tag_id     <= w_tag_id_nxt;
      r_tag_close  <= w_tag_close_nxt;
      r_attr_valid <= w_attr_valid_nxt;
      r_attr_id    <= w_attr_id_nxt;
      r_attr_value <= w_attr_value_nxt;
      r_text_valid <= w_text_valid_nxt;
      r_text_char  <= w_text_char_nxt;
      r_finished   <= w_finished_nxt;
      r_error      <= w_error_nxt;
    end
  end

  assign o_tag_valid    = r_tag_valid;
  assign o_tag_id       = r_tag_id;
  assign o_tag_is_close = r_tag_close;
  assign o_attr_valid   = r_attr_valid;
  assign o_attr_id      = r_attr_id;
  assign o_attr_value   = r_attr_value;
  assign o_text_valid   = r_text_valid;
  assign o_text_char    = r_text_char;
  assign o_has_finished = r_finished;
  assign o_error        = r_error;

endmodule

// File: tb/tb_html_tag_parser.sv
// Scoreboard bench for html_tag_parser: a string-level reference tokenizer
// fills an expected-token queue, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_html_tag_parser;
  localparam int NAME_LEN = 10;

  typedef logic [7:0] ch_t;
  typedef ch_t chq_t[$];
  typedef struct packed {
    logic [1:0] kind;   // 1 tag, 2 attr, 3 text
    logic [1:0] id;
    logic       flag;   // close flag for tags
    logic [3:0] val;
    logic [7:0] ch;
  } tok_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, state_enable, char_valid;
  logic [7:0] ch;
  logic       tag_valid, tag_is_close, attr_valid, text_valid, has_finished, error;
  logic [1:0] tag_id, attr_id;
  logic [3:0] attr_value;
  logic [7:0] text_char;

  html_tag_parser #(.NAME_LEN(NAME_LEN)) dut (
    .i_clock(clk), .i_reset(reset), .i_state_enable(state_enable),
    .i_char(ch), .i_char_valid(char_valid),
    .o_tag_valid(tag_valid), .o_tag_id(tag_id), .o_tag_is_close(tag_is_close),
    .o_attr_valid(attr_valid), .o_attr_id(attr_id), .o_attr_value(attr_value),
    .o_text_valid(text_valid), .o_text_char(text_char),
    .o_has_finished(has_finished), .o_error(error)
  );

  tok_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   exp_fin, exp_err;
  tok_t mon_act, mon_exp;

  // ---------------- reference model (string-level tokenizer) ----------------
  function automatic bit is_letter(ch_t c);
    return ((c >= "a") && (c <= "z")) || ((c >= "A") && (c <= "Z"));
  endfunction

  function automatic bit is_digit(ch_t c);
    return (c >= "0") && (c <= "9");
  endfunction

  function automatic tok_t mk(int kind, int id, bit flag, int val, ch_t c);
    tok_t t;
    t.kind = 2'(kind); t.id = 2'(id); t.flag = flag; t.val = 4'(val); t.ch = c;
    return t;
  endfunction

  function automatic bit same(chq_t nm, string s);
    if (nm.size() != s.len()) return 1'b0;
    for (int j = 0; j < nm.size(); j++) if (nm[j] != ch_t'(s[j])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int lookup(chq_t nm, bit is_attr);
    if (nm.size() > NAME_LEN) return 0;
    if (is_attr) begin
      if (same(nm, "background")) return 1;
      if (same(nm, "color")) return 2;
      if (same(nm, "size")) return 3;
    end else begin
      if (same(nm, "body")) return 1;
      if (same(nm, "p")) return 2;
    end
    return 0;
  endfunction

  // Malformed at position i: error, and a '\0' from i onward still finishes.
  function automatic void fail_at(chq_t s, int i);
    exp_err = 1'b1;
    for (int k = i; k < s.size(); k++) if (s[k] == 8'h00) exp_fin = 1'b1;
  endfunction

  // Parse one tag body starting after '<'. Returns 1 when the tag closed
  // cleanly and text resumes; 0 when the stream stopped (ran out or failed).
  function automatic bit parse_tag(chq_t s, inout int i);
    bit   close;
    chq_t nm;
    int   n, val, nd;
    n = s.size();
    close = 1'b0;
    if (i < n && s[i] == "/") begin close = 1'b1; i++; end
    if (i >= n) return 1'b0;
    if (!is_letter(s[i])) begin fail_at(s, i); return 1'b0; end
    while (i < n && is_letter(s[i])) begin nm.push_back(s[i]); i++; end
    if (i >= n) return 1'b0;
    if (s[i] != ">" && s[i] != " ") begin fail_at(s, i); return 1'b0; end
    exp_q.push_back(mk(1, lookup(nm, 1'b0), close, 0, 8'h00));
    if (s[i] == ">") begin i++; return 1'b1; end
    i++;
    while (1'b1) begin
      while (i < n && s[i] == " ") i++;
      if (i >= n) return 1'b0;
      if (s[i] == ">") begin i++; return 1'b1; end
      if (close || !is_letter(s[i])) begin fail_at(s, i); return 1'b0; end
      nm.delete();
      while (i < n && is_letter(s[i])) begin nm.push_back(s[i]); i++; end
      if (i >= n) return 1'b0;
      if (s[i] != "=") begin fail_at(s, i); return 1'b0; end
      i++;
      val = 0; nd = 0;
      while (i < n && is_digit(s[i])) begin
        if (val < 1000) val = val * 10 + int'(s[i] - 8'h30);
        nd++; i++;
      end
      if (i >= n) return 1'b0;
      if (nd == 0 || (s[i] != " " && s[i] != ">")) begin fail_at(s, i); return 1'b0; end
      exp_q.push_back(mk(2, lookup(nm, 1'b1), 1'b0, (val > 15) ? 15 : val, 8'h00));
      if (s[i] == ">") begin i++; return 1'b1; end
      i++;
    end
    return 1'b0;
  endfunction

  function automatic void run_model(chq_t s);
    int i;
    exp_fin = 1'b0; exp_err = 1'b0; i = 0;
    while (i < s.size()) begin
      if (s[i] == 8'h00) begin exp_fin = 1'b1; return; end
      else if (s[i] != "<") begin exp_q.push_back(mk(3, 0, 1'b0, 0, s[i])); i++; end
      else begin i++; if (!parse_tag(s, i)) return; end
    end
  endfunction

  // ---------------- stream builders ----------------
  function automatic chq_t cat_str(chq_t q, string s);
    for (int k = 0; k < s.len(); k++) q.push_back(ch_t'(s[k]));
    return q;
  endfunction

  function automatic chq_t mkq(string s, bit nul);
    chq_t q;
    q = cat_str(q, s);
    if (nul) q.push_back(8'h00);
    return q;
  endfunction

  function automatic chq_t gen_stream();
    chq_t  q, t, bad;
    string names[12];
    string pool;
    int    np;
    names = '{"body", "p", "div", "background", "color", "size",
              "bodyy", "backgroundx", "Body", "bod", "sizes", "colorcolor"};
    pool  = "ab> 1/=Z";
    bad   = '{8'h3C, 8'h2F, 8'h3D, 8'h3E, 8'h31, 8'h20, 8'h78, 8'h00};
    np = $urandom_range(1, 6);
    for (int p = 0; p < np; p++) begin
      int r;
      r = $urandom_range(0, 2);
      if (r == 0) begin
        int nt;
        nt = $urandom_range(1, 4);
        for (int k = 0; k < nt; k++) q.push_back(ch_t'(pool[$urandom_range(0, 7)]));
      end else begin
        bit close;
        t.delete();
        t.push_back("<");
        close = ($urandom_range(0, 3) == 0);
        if (close) t.push_back("/");
        t = cat_str(t, names[$urandom_range(0, 11)]);
        if (!close) begin
          int na;
          na = $urandom_range(0, 2);
          for (int a = 0; a < na; a++) begin
            int nd;
            repeat ($urandom_range(1, 2)) t.push_back(" ");
            t = cat_str(t, names[$urandom_range(0, 11)]);
            t.push_back("=");
            nd = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
            for (int d = 0; d < nd; d++) t.push_back(8'h30 + 8'($urandom_range(0, 9)));
          end
        end
        if ($urandom_range(0, 3) == 0) t.push_back(" ");
        t.push_back(">");
        if (r == 2) t.insert($urandom_range(0, t.size()), bad[$urandom_range(0, 7)]);
        for (int k = 0; k < t.size(); k++) q.push_back(t[k]);
      end
    end
    if ($urandom_range(0, 4) != 0) begin
      q.push_back(8'h00);
      if ($urandom_range(0, 1) == 1) q = cat_str(q, "a<p>");
    end
    return q;
  endfunction

  // ---------------- monitor ----------------
  // Pop one expected token per presented DUT token and compare.
  always @(negedge clk) begin
    if (tag_valid || attr_valid || text_valid) begin
      mon_act = '0;
      if (tag_valid) begin
        mon_act.kind = 2'd1; mon_act.id = tag_id; mon_act.flag = tag_is_close;
      end else if (attr_valid) begin
        mon_act.kind = 2'd2; mon_act.id = attr_id; mon_act.val = attr_value;
      end else begin
        mon_act.kind = 2'd3; mon_act.ch = text_char;
      end
      checks++;
      if ((int'(tag_valid) + int'(attr_valid) + int'(text_valid)) > 1) begin
        errors++;
        $display("FAIL onehot: got tag=%0b attr=%0b text=%0b, required at most one valid",
                 tag_valid, attr_valid, text_valid);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_token: got kind=%0d id=%0d flag=%0d val=%0d ch=%02h, required none",
                 mon_act.kind, mon_act.id, mon_act.flag, mon_act.val, mon_act.ch);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL token: got kind=%0d id=%0d flag=%0d val=%0d ch=%02h, required kind=%0d id=%0d flag=%0d val=%0d ch=%02h",
                   mon_act.kind, mon_act.id, mon_act.flag, mon_act.val, mon_act.ch,
                   mon_exp.kind, mon_exp.id, mon_exp.flag, mon_exp.val, mon_exp.ch);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic send(input chq_t s, input bit gaps);
    for (int k = 0; k < s.size(); k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          char_valid = 1'b0; ch = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      char_valid = 1'b1; ch = s[k];
      @(posedge clk); #1;
    end
    char_valid = 1'b0; ch = 8'h00;
  endtask

  task automatic run_seg(input chq_t s, input bit gaps);
    run_model(s);
    send(s, gaps);
    repeat (3) begin @(posedge clk); #1; end
    chk("tokens_pending", exp_q.size(), 0);
    exp_q.delete();
    chk("has_finished", int'(has_finished), int'(exp_fin));
    chk("error", int'(error), int'(exp_err));
  endtask

  task automatic do_reset(input bit via_enable);
    if (via_enable) state_enable = 1'b0; else reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; state_enable = 1'b1;
    chk(via_enable ? "enable_low_outputs" : "reset_outputs",
        int'({tag_valid, tag_id, tag_is_close, attr_valid, attr_id, attr_value,
              text_valid, text_char, has_finished, error}), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; state_enable = 1'b1; char_valid = 1'b0; ch = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_outputs", int'({tag_valid, tag_id, tag_is_close, attr_valid, attr_id,
        attr_value, text_valid, text_char, has_finished, error}), 0);

    run_seg(mkq("<body background=3><p color=1 size=2>test</p></body>", 1'b1), 1'b0);
    do_reset(1'b0);
    run_seg(mkq("<body background=3><p color=1 size=2>test</p></body>", 1'b1), 1'b1);
    do_reset(1'b1);
    run_seg(mkq("<p size=99>", 1'b1), 1'b1);
    do_reset(1'b0);
    run_seg(mkq("<div x=5>a", 1'b1), 1'b0);
    do_reset(1'b0);
    run_seg(mkq("<p color=>x", 1'b1), 1'b1);
    do_reset(1'b0);
    run_seg(mkq("<body", 1'b0), 1'b1);
    do_reset(1'b0);
    run_seg(mkq("ab", 1'b1), 1'b1);
    do_reset(1'b1);
    run_seg(mkq("<backgroundx backgroundx=7 background=12>", 1'b1), 1'b0);
    do_reset(1'b0);
    run_seg(mkq("</p x=1>q", 1'b1), 1'b0);
    do_reset(1'b0);
    run_seg(mkq("<//p>", 1'b1), 1'b0);
    do_reset(1'b0);

    for (int r = 0; r < 40; r++) begin
      run_seg(gen_stream(), ($urandom_range(0, 1) == 1));
      do_reset(($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
